// File: rtl/soc_vga_scanout_if.sv
// Framebuffer read-port bundle between the scanout engine and the
// framebuffer's port B: byte address out, byte data back one cycle later.
interface soc_vga_scanout_if #(
    parameter int ADDR_WIDTH_B = 32
);
    logic [ADDR_WIDTH_B-1:0] word_addr_b;
    logic [7:0]              read_data_b;

    modport master (output word_addr_b, input  read_data_b);
    modport slave  (input  word_addr_b, output read_data_b);
endinterface

// File: rtl/soc_vga_scanout.sv
// VGA timing generator and RGB332 scanout. Stage 0 holds the raster
// counters and drives the framebuffer address; stage 1 waits out the
// framebuffer read latency; stage 2 registers pins so syncs and colour
// leave together two cycles after the counter state.
module soc_vga_scanout #(
    parameter int ADDR_WIDTH_B = 32,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int FB_WIDTH     = 320
) (
    input  logic               vga_clk,
    input  logic               res,
    input  logic               display_en,
    soc_vga_scanout_if.master  fb,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vblank,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FB_WIDTH * (V_ACTIVE / 2));

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active0;
    logic [AW-1:0] row_base;
    logic [AW-1:0] pix_addr;

    logic s1_active, s1_hs, s1_vs, s1_vblank, s1_fs;

    // Raster counters: h wraps every line, v advances on the h wrap edge
    always_ff @(posedge vga_clk or negedge res) begin
        if (!res) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // Row base for the halved y; the 320-byte pitch reduces to two shifts
    if (FB_WIDTH == 320) begin : g_pitch320
        always_comb begin
            row_base = (AW'(v_cnt[VW-1:1]) << 8) + (AW'(v_cnt[VW-1:1]) << 6);
        end
    end else begin : g_pitch_mul
        always_comb begin
            row_base = AW'(v_cnt[VW-1:1]) * AW'(FB_WIDTH);
        end
    end

    // Byte address for the current pixel; parked at 0 while blanking
    always_comb begin
        pix_addr       = row_base + AW'(h_cnt[HW-1:1]);
        fb.word_addr_b = active0 ? ADDR_WIDTH_B'(pix_addr) : '0;
    end

    // Stage 1: timing flags travel alongside the framebuffer read
    always_ff @(posedge vga_clk or negedge res) begin
        if (!res) begin
            s1_active <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_vblank <= 1'b0;
            s1_fs     <= 1'b0;
        end else begin
            s1_active <= active0;
            s1_hs     <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
            s1_vs     <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
            s1_vblank <= (v_cnt >= V_ACT);
            s1_fs     <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Stage 2: expand RGB332 to 4-4-4 and register all pins together
    always_ff @(posedge vga_clk or negedge res) begin
        if (!res) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (s1_active && display_en) begin
                vga_r <= {fb.read_data_b[7:5], fb.read_data_b[7]};
                vga_g <= {fb.read_data_b[4:2], fb.read_data_b[4]};
                vga_b <= {fb.read_data_b[1:0], fb.read_data_b[1:0]};
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
            vga_hs      <= s1_hs;
            vga_vs      <= s1_vs;
            vblank      <= s1_vblank;
            frame_start <= s1_fs;
        end
    end
endmodule
